// File: rtl/sram_bist_pkg.sv
// Shared state type and March C- element tables for the SRAM BIST controller.
// Tables are bit-masks indexed by march_state_e, so each state maps directly to its element's properties.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_M0    = 3'd1,
        S_M1    = 3'd2,
        S_M2    = 3'd3,
        S_M3    = 3'd4,
        S_M4    = 3'd5,
        S_M5    = 3'd6,
        S_FLUSH = 3'd7
    } march_state_e;

    // Bit n of each mask describes the element encoded as state value n.
    localparam logic [7:0] ELEM_TWO_OPS = 8'b0011_1100;  // M1..M4 do read-then-write
    localparam logic [7:0] ELEM_DESC    = 8'b0111_0000;  // M3..M5 walk downwards
    localparam logic [7:0] ELEM_OP0_RD  = 8'b0111_1100;  // first op is a read
    localparam logic [7:0] ELEM_OP0_VAL = 8'b0010_1000;  // background of first op
    localparam logic [7:0] ELEM_OP1_VAL = 8'b0001_0100;  // background of second op (always a write)

    localparam logic BG_ZERO = 1'b0;
    localparam logic BG_ONES = 1'b1;

    function automatic logic is_march(input march_state_e s);
        return (s != S_IDLE) && (s != S_FLUSH);
    endfunction

endpackage

// File: rtl/sram_bist_cmp.sv
// Read-compare stage: registers each issued read's expected word and address, checks
// the SRAM output one cycle later, and keeps sticky fail, first fail address and a saturating count.
module sram_bist_cmp #(
    parameter int P_DATA_WIDTH   = 24,
    parameter int P_ADDR_WIDTH   = 14,
    parameter int P_ERRCNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      rd_vld_i,
    input  logic [P_DATA_WIDTH-1:0]   exp_i,
    input  logic [P_ADDR_WIDTH-1:0]   addr_i,
    input  logic [P_DATA_WIDTH-1:0]   dout_i,
    output logic                      fail_o,
    output logic [P_ADDR_WIDTH-1:0]   fail_addr_o,
    output logic [P_ERRCNT_WIDTH-1:0] err_cnt_o
);

    logic                      cmp_vld_q;
    logic [P_DATA_WIDTH-1:0]   exp_q;
    logic [P_ADDR_WIDTH-1:0]   cmp_addr_q;
    logic                      fail_q, fail_d;
    logic [P_ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [P_ERRCNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                      miscmp;

    assign miscmp = cmp_vld_q && (dout_i != exp_q);

    always_comb begin
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        err_cnt_d   = err_cnt_q;
        if (clr_i) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            err_cnt_d   = '0;
        end else if (miscmp) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = cmp_addr_q;
            end
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_vld_q   <= 1'b0;
            exp_q       <= '0;
            cmp_addr_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            cmp_vld_q   <= rd_vld_i;
            exp_q       <= exp_i;
            cmp_addr_q  <= addr_i;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST controller owning the SRAM port; passes the functional requester through when idle.
// One op per cycle for 10*2^P_ADDR_WIDTH cycles plus one flush cycle; functional side is never stalled.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH   = 24,
    parameter int P_ADDR_WIDTH   = 14,
    parameter int P_ERRCNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fail_o,
    output logic [P_ADDR_WIDTH-1:0]   fail_addr_o,
    output logic [P_ERRCNT_WIDTH-1:0] err_cnt_o,
    input  logic [P_ADDR_WIDTH-1:0]   func_addr_i,
    input  logic [P_DATA_WIDTH-1:0]   func_din_i,
    input  logic                      func_men_i,
    input  logic                      func_wen_i,
    input  logic                      func_ren_i,
    output logic [P_ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [P_DATA_WIDTH-1:0]   sram_din_o,
    output logic                      sram_men_o,
    output logic                      sram_wen_o,
    output logic                      sram_ren_o,
    input  logic [P_DATA_WIDTH-1:0]   sram_dout_i
);

    march_state_e              state_q, state_d, state_nxt_elem;
    logic                      op_q, op_d;
    logic [P_ADDR_WIDTH-1:0]   addr_q, addr_d, term_addr;
    logic                      men_q, men_d, wen_q, wen_d, ren_q, ren_d;
    logic [P_DATA_WIDTH-1:0]   din_q, din_d;
    logic                      done_q, done_d;
    logic                      is_rd, bg_val, busy;

    assign busy           = (state_q != S_IDLE);
    assign state_nxt_elem = march_state_e'(state_q + 3'd1);
    assign term_addr      = ELEM_DESC[state_q] ? '0 : '1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_M0;
                    op_d    = 1'b0;
                    addr_d  = '0;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: begin
                if (ELEM_TWO_OPS[state_q] && !op_q) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (addr_q == term_addr) begin
                        if (state_q == S_M5) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d = state_nxt_elem;
                            addr_d  = ELEM_DESC[state_nxt_elem] ? '1 : '0;
                        end
                    end else begin
                        addr_d = ELEM_DESC[state_q] ? addr_q - 1'b1 : addr_q + 1'b1;
                    end
                end
            end
        endcase

        // Decode the op for the cycle after this edge so the SRAM pins come straight from flops.
        is_rd  = op_d ? 1'b0 : ELEM_OP0_RD[state_d];
        bg_val = op_d ? ELEM_OP1_VAL[state_d] : ELEM_OP0_VAL[state_d];
        men_d  = is_march(state_d);
        wen_d  = men_d && !is_rd;
        ren_d  = men_d && is_rd;
        din_d  = bg_val ? {P_DATA_WIDTH{BG_ONES}} : {P_DATA_WIDTH{BG_ZERO}};
        done_d = (state_d == S_FLUSH);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            addr_q  <= '0;
            men_q   <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            men_q   <= men_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    // For reads din_q carries the expected background, which the compare stage picks up.
    sram_bist_cmp #(
        .P_DATA_WIDTH   (P_DATA_WIDTH),
        .P_ADDR_WIDTH   (P_ADDR_WIDTH),
        .P_ERRCNT_WIDTH (P_ERRCNT_WIDTH)
    ) u_cmp (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (start_i && !busy),
        .rd_vld_i    (ren_q),
        .exp_i       (din_q),
        .addr_i      (addr_q),
        .dout_i      (sram_dout_i),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .err_cnt_o   (err_cnt_o)
    );

    assign busy_o      = busy;
    assign done_o      = done_q;
    assign sram_addr_o = busy ? addr_q : func_addr_i;
    assign sram_din_o  = busy ? din_q  : func_din_i;
    assign sram_men_o  = busy ? men_q  : func_men_i;
    assign sram_wen_o  = busy ? wen_q  : func_wen_i;
    assign sram_ren_o  = busy ? ren_q  : func_ren_i;

endmodule
